// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - Transmit request/status bundle for uart_tx
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tx_start;
   logic [DATA_WIDTH-1:0] tx_din;
   logic                  tx;
   logic                  tx_ready;
   logic                  tx_done_tk;

   modport master (
      output tx_start, tx_din,
      input  tx, tx_ready, tx_done_tk
   );

   modport slave (
      input  tx_start, tx_din,
      output tx, tx_ready, tx_done_tk
   );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - Oversampled UART transmitter: start, LSB-first data, optional parity, stop
module uart_tx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_WIDTH = 8,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic     BCLK,
   input  logic     reset,
   uart_tx_if.slave bus
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  parity_q, parity_d;
   logic                  tx_q, tx_d;
   logic                  tick_end;

   assign tick_end = (tick_q == TICK_LAST);

   always_ff @(posedge BCLK or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
      end
   end

   // tx_d is the line value for the cycle after this edge, so each bit lands exactly on its boundary.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tx_d     = tx_q;
      case (state_q)
         IDLE: begin
            tick_d = '0;
            tx_d   = 1'b1;
            if (bus.tx_start) begin
               state_d  = START;
               shift_d  = bus.tx_din;
               parity_d = (^bus.tx_din) ^ PARITY_ODD;
               bit_d    = '0;
               tx_d     = 1'b0;
            end
         end
         START: begin
            if (tick_end) begin
               state_d = DATA;
               tick_d  = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tick_end) begin
               tick_d = '0;
               if (bit_q == BIT_LAST) begin
                  if (PARITY_EN) begin
                     state_d = PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (tick_end) begin
               state_d = STOP;
               tick_d  = '0;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (tick_end) begin
               state_d = IDLE;
               tick_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign bus.tx         = tx_q;
   assign bus.tx_ready   = (state_q == IDLE);
   assign bus.tx_done_tk = (state_q == STOP) && tick_end;
endmodule
